// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length codes, round counts, controller encodings
// and the GF(2^8) doubling used by both key expansion and the encipher block.
package aes_pkg;

    localparam logic       AES_128_BIT_KEY = 1'b0;
    localparam logic       AES_256_BIT_KEY = 1'b1;

    localparam logic [3:0] AES128_ROUNDS   = 4'ha;
    localparam logic [3:0] AES256_ROUNDS   = 4'he;

    // gm2(RCON_INIT) == 8'h01, so the first advance yields the first round constant.
    localparam logic [7:0] RCON_INIT       = 8'h8d;

    typedef enum logic [1:0] {
        CTRL_IDLE     = 2'd0,
        CTRL_GENERATE = 2'd1,
        CTRL_DONE     = 2'd2
    } ctrl_state_e;

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-expansion bus: init/key request, round-key read port and the borrowed
// S-box word port. The consumer side is master, the expander is slave.
interface aes_key_expand_if;

    logic         init;
    logic [255:0] key;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;
    logic         ready;

    modport master (
        output init, key, keylen, round, new_sboxw,
        input  round_key, sboxw, ready
    );

    modport slave (
        input  init, key, keylen, round, new_sboxw,
        output round_key, sboxw, ready
    );

endinterface

// File: rtl/aes_key_store.sv
// Round-key register file: async clear, one synchronous write port and one
// combinational read port; addresses at or beyond NUM_KEYS read as zero.
module aes_key_store #(
    parameter int NUM_KEYS = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_we,
    input  logic [3:0]   i_waddr,
    input  logic [127:0] i_wdata,
    input  logic [3:0]   i_raddr,
    output logic [127:0] o_rdata
);

    logic [127:0] r_mem [0:NUM_KEYS-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (int'(i_waddr) < NUM_KEYS)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata = '0;
        if (int'(i_raddr) < NUM_KEYS) begin
            o_rdata = r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128/256 key expansion: writes one round key per cycle into the key store,
// borrowing the shared S-box through sboxw/new_sboxw while generating.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NUM_KEYS = 15
) (
    input  logic             clk,
    input  logic             reset,
    aes_key_expand_if.slave  bus
);

    ctrl_state_e  r_state;
    ctrl_state_e  w_state_next;

    logic         r_ready;
    logic [3:0]   r_round_ctr;
    logic [7:0]   r_rcon;
    logic         r_keylen;
    logic [255:0] r_key;
    logic [127:0] r_prev1;
    logic [127:0] r_prev2;

    logic         w_start;
    logic         w_we;
    logic         w_last;
    logic [3:0]   w_num_rounds;
    logic         w_from_key;
    logic         w_use_rcon;
    logic [7:0]   w_rcon_next;
    logic [31:0]  w_sboxw;
    logic [31:0]  w_t;
    logic [127:0] w_old;
    logic [127:0] w_new_key;

    function automatic logic [127:0] chain_words(input logic [127:0] old_key,
                                                 input logic [31:0]  t);
        logic [31:0] w0, w1, w2, w3;
        w0 = old_key[127:96] ^ t;
        w1 = old_key[95:64]  ^ w0;
        w2 = old_key[63:32]  ^ w1;
        w3 = old_key[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    assign w_num_rounds = (r_keylen == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
    assign w_last       = (r_round_ctr == w_num_rounds);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= CTRL_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_we         = 1'b0;
        case (r_state)
            CTRL_IDLE: begin
                if (bus.init) begin
                    w_start      = 1'b1;
                    w_state_next = CTRL_GENERATE;
                end
            end
            CTRL_GENERATE: begin
                w_we = 1'b1;
                if (w_last) begin
                    w_state_next = CTRL_DONE;
                end
            end
            CTRL_DONE: begin
                w_state_next = CTRL_IDLE;
            end
            default: begin
                w_state_next = CTRL_IDLE;
            end
        endcase
    end

    // Entry 0 (and entry 1 for AES-256) come straight from the key; the S-box
    // word is only presented when an entry is derived from earlier ones.
    always_comb begin
        w_from_key  = (r_round_ctr == 4'd0) ||
                      ((r_keylen == AES_256_BIT_KEY) && (r_round_ctr == 4'd1));
        w_use_rcon  = (r_keylen == AES_128_BIT_KEY) || !r_round_ctr[0];
        w_rcon_next = r_rcon;
        w_sboxw     = '0;
        if ((r_state == CTRL_GENERATE) && !w_from_key) begin
            if (w_use_rcon) begin
                w_sboxw     = rot_word(r_prev1[31:0]);
                w_rcon_next = gm2(r_rcon);
            end else begin
                w_sboxw     = r_prev1[31:0];
            end
        end
    end

    always_comb begin
        w_t       = bus.new_sboxw;
        w_old     = (r_keylen == AES_256_BIT_KEY) ? r_prev2 : r_prev1;
        w_new_key = '0;
        if (r_round_ctr == 4'd0) begin
            w_new_key = r_key[255:128];
        end else if (w_from_key) begin
            w_new_key = r_key[127:0];
        end else begin
            if (w_use_rcon) begin
                w_t = bus.new_sboxw ^ {w_rcon_next, 24'h0};
            end
            w_new_key = chain_words(w_old, w_t);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready     <= 1'b1;
            r_round_ctr <= '0;
            r_rcon      <= RCON_INIT;
            r_keylen    <= AES_128_BIT_KEY;
        end else begin
            if (w_start) begin
                r_ready     <= 1'b0;
                r_round_ctr <= '0;
                r_rcon      <= RCON_INIT;
                r_keylen    <= bus.keylen;
            end
            if (w_we) begin
                r_rcon <= w_rcon_next;
                if (!w_last) begin
                    r_round_ctr <= r_round_ctr + 4'd1;
                end
            end
            if (r_state == CTRL_DONE) begin
                r_ready <= 1'b1;
            end
        end
    end

    // Working copies of the key and the last two entries need no reset.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_key <= bus.key;
        end
        if (w_we) begin
            r_prev2 <= r_prev1;
            r_prev1 <= w_new_key;
        end
    end

    aes_key_store #(
        .NUM_KEYS (NUM_KEYS)
    ) u_store (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we),
        .i_waddr (r_round_ctr),
        .i_wdata (w_new_key),
        .i_raddr (bus.round),
        .o_rdata (bus.round_key)
    );

    assign bus.sboxw = w_sboxw;
    assign bus.ready = r_ready;

endmodule
